// File: rtl/huffman_pkg.sv
// Shared types and width helpers for the Huffman code-length builder.
package huffman_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_MERGE,
    S_DONE
  } state_t;

  // Weight width: the sum of n_sym counts of cnt_w bits always fits.
  function automatic int calc_w_w(input int n_sym, input int cnt_w);
    return cnt_w + $clog2(n_sym);
  endfunction

  function automatic int calc_len_w(input int n_sym);
    return $clog2(n_sym) + 1;
  endfunction

  localparam int DEF_N_SYM = 6;
  localparam int DEF_CNT_W = 8;

  // Tree node for the default build; the top re-declares it for its own parameters.
  typedef struct packed {
    logic [calc_w_w(DEF_N_SYM, DEF_CNT_W)-1:0] weight;
    logic [DEF_N_SYM-1:0]                      mask;
  } node_t;

endpackage

// File: rtl/huffman_cmp_swap.sv
// One compare-exchange cell: puts the heavier node on the a side, ties keep order.
// Purely combinational; no flow control.
module huffman_cmp_swap
  import huffman_pkg::*;
#(
  parameter type T_NODE = node_t
) (
  input  logic  i_en,
  input  T_NODE i_a,
  input  T_NODE i_b,
  output T_NODE o_a,
  output T_NODE o_b
);

  logic w_swap;

  assign w_swap = i_en && (i_b.weight > i_a.weight);
  assign o_a    = w_swap ? i_b : i_a;
  assign o_b    = w_swap ? i_a : i_b;

endmodule

// File: rtl/huffman_tree_builder.sv
// Huffman code-length builder: odd-even transposition sort, then merge the two lightest nodes.
// Multi-cycle start/busy/done handshake; HUFF_SKIP_ZERO_EN excludes zero-count symbols.
module huffman_tree_builder
  import huffman_pkg::*;
#(
  parameter  int N_SYM = 6,
  parameter  int CNT_W = 8,
  localparam int W_W   = calc_w_w(N_SYM, CNT_W),
  localparam int LEN_W = calc_len_w(N_SYM),
  localparam int AW    = $clog2(N_SYM + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [N_SYM*CNT_W-1:0] i_counts,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [N_SYM*LEN_W-1:0] o_code_len
);

  typedef struct packed {
    logic [W_W-1:0]   weight;
    logic [N_SYM-1:0] mask;
  } bnode_t;

  state_t                 r_state, w_state_nxt;
  logic [N_SYM*CNT_W-1:0] r_counts;
  bnode_t                 r_node      [N_SYM];
  bnode_t                 w_node_nxt  [N_SYM];
  bnode_t                 w_load_node [N_SYM];
  bnode_t                 w_ph        [N_SYM];
  bnode_t                 w_ca        [N_SYM-1];
  bnode_t                 w_cb        [N_SYM-1];
  logic [N_SYM-2:0]       w_en;
  logic [LEN_W-1:0]       r_len      [N_SYM];
  logic [LEN_W-1:0]       w_len_nxt  [N_SYM];
  logic [LEN_W-1:0]       w_load_len [N_SYM];
  logic [AW-1:0]          r_act, w_act_nxt, w_load_act;
  logic                   r_phase, w_phase_nxt, w_sorted_nxt;
  logic [N_SYM-1:0]       w_part, w_mrg_mask;

`ifdef HUFF_SKIP_ZERO_EN
  for (genvar i = 0; i < N_SYM; i++) begin : g_part
    assign w_part[i] = |r_counts[i*CNT_W +: CNT_W];
  end
`else
  assign w_part = '1;
`endif

  // Compact participating symbols to positions 0..act-1, preserving index order.
  always_comb begin
    int pos;
    pos = 0;
    for (int i = 0; i < N_SYM; i++) begin
      w_load_node[i] = '0;
      w_load_len[i]  = '0;
    end
    for (int i = 0; i < N_SYM; i++) begin
      if (w_part[i]) begin
        for (int p = 0; p < N_SYM; p++) begin
          if (p == pos) begin
            w_load_node[p].weight  = W_W'(r_counts[i*CNT_W +: CNT_W]);
            w_load_node[p].mask[i] = 1'b1;
          end
        end
        pos = pos + 1;
      end
    end
    w_load_act = AW'(pos);
    for (int i = 0; i < N_SYM; i++) begin
      if (pos == 1 && w_part[i]) w_load_len[i] = LEN_W'(1);
    end
  end

  for (genvar k = 0; k < N_SYM - 1; k++) begin : g_cell
    localparam logic PAR = logic'(k % 2);
    assign w_en[k] = (PAR == r_phase) && ((k + 1) < int'(r_act));
    huffman_cmp_swap #(.T_NODE(bnode_t)) u_cell (
      .i_en (w_en[k]),
      .i_a  (r_node[k]),
      .i_b  (r_node[k+1]),
      .o_a  (w_ca[k]),
      .o_b  (w_cb[k])
    );
  end

  // Each position is the a side of the active-parity cell or the b side of its left neighbour.
  for (genvar p = 0; p < N_SYM; p++) begin : g_ph
    localparam logic PAR = logic'(p % 2);
    if (p == 0) begin : g_first
      assign w_ph[p] = (PAR == r_phase) ? w_ca[p] : r_node[p];
    end else if (p == N_SYM - 1) begin : g_last
      assign w_ph[p] = (PAR == r_phase) ? r_node[p] : w_cb[p-1];
    end else begin : g_mid
      assign w_ph[p] = (PAR == r_phase) ? w_ca[p] : w_cb[p-1];
    end
  end

  always_comb begin
    w_node_nxt  = r_node;
    w_len_nxt   = r_len;
    w_act_nxt   = r_act;
    w_phase_nxt = r_phase;
    w_mrg_mask  = '0;
    case (r_state)
      S_LOAD: begin
        w_node_nxt  = w_load_node;
        w_len_nxt   = w_load_len;
        w_act_nxt   = w_load_act;
        w_phase_nxt = 1'b0;
      end
      S_SORT: begin
        w_node_nxt  = w_ph;
        w_phase_nxt = ~r_phase;
      end
      S_MERGE: begin
        for (int k = 0; k < N_SYM - 1; k++) begin
          if (int'(r_act) == k + 2) begin
            w_node_nxt[k].weight = r_node[k].weight + r_node[k+1].weight;
            w_node_nxt[k].mask   = r_node[k].mask | r_node[k+1].mask;
            w_node_nxt[k+1]      = '0;
            w_mrg_mask           = r_node[k].mask | r_node[k+1].mask;
          end
        end
        for (int i = 0; i < N_SYM; i++) begin
          if (w_mrg_mask[i]) w_len_nxt[i] = r_len[i] + LEN_W'(1);
        end
        w_act_nxt   = r_act - AW'(1);
        w_phase_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Sortedness of the upcoming active range, so an ordered range spends no SORT cycle.
  always_comb begin
    w_sorted_nxt = 1'b1;
    for (int k = 0; k < N_SYM - 1; k++) begin
      if (((k + 1) < int'(w_act_nxt)) && (w_node_nxt[k+1].weight > w_node_nxt[k].weight))
        w_sorted_nxt = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_act_nxt <= AW'(1)) w_state_nxt = S_DONE;
        else if (w_sorted_nxt)   w_state_nxt = S_MERGE;
        else                     w_state_nxt = S_SORT;
      end
      S_SORT:  if (w_sorted_nxt) w_state_nxt = S_MERGE;
      S_MERGE: begin
        if (w_act_nxt == AW'(1)) w_state_nxt = S_DONE;
        else if (w_sorted_nxt)   w_state_nxt = S_MERGE;
        else                     w_state_nxt = S_SORT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_counts <= '0;
      r_act    <= '0;
      r_phase  <= 1'b0;
      for (int i = 0; i < N_SYM; i++) begin
        r_node[i] <= '0;
        r_len[i]  <= '0;
      end
    end else begin
      if (r_state == S_IDLE && i_start) r_counts <= i_counts;
      r_act   <= w_act_nxt;
      r_phase <= w_phase_nxt;
      for (int i = 0; i < N_SYM; i++) begin
        r_node[i] <= w_node_nxt[i];
        r_len[i]  <= w_len_nxt[i];
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);

  for (genvar i = 0; i < N_SYM; i++) begin : g_out
    assign o_code_len[i*LEN_W +: LEN_W] = r_len[i];
  end

endmodule

// File: doc/huffman_tree_builder.md
# huffman_tree_builder

Parametrised Huffman code-length generator that sits after the symbol counter and before the codeword assigner in the Huffman encoder. It loads N_SYM symbol counts and repeatedly sorts the active nodes descending by weight with an odd-even transposition network. It then merges the two lightest nodes until one node remains, and outputs a code length for each symbol. Per-node membership bitmasks replace fixed 3-bit packed symbol lists, so any symbol count and tree depth is supported.

## Interface
- N_SYM, 6, number of symbols (>= 2)
- CNT_W, 8, width of each input count
- W_W, derived CNT_W+$clog2(N_SYM), internal weight width; sums never overflow
- LEN_W, derived $clog2(N_SYM)+1, code-length field width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- counts  in  N_SYM*CNT_W  symbol i count at [i*CNT_W +: CNT_W]; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when code_len becomes valid
- code_len  out  N_SYM*LEN_W  length of symbol i at [i*LEN_W +: LEN_W]; held until the next accepted start

## Operation
- States: IDLE, LOAD, SORT, MERGE, DONE.
- IDLE: start=1 captures counts and moves to LOAD. start outside IDLE is ignored.
- LOAD: node i gets weight=count[i] and mask=one-hot(i). All code_len cleared to 0. act = number of participating nodes, which are compacted to positions 0..act-1. Next state SORT.
- SORT: each cycle applies one phase over positions 0..act-1, alternating even pairs (0/1, 2/3, …) and odd pairs (1/2, …), starting with even. Swap only if w[k+1] > w[k] strictly, so ties keep their current order. Leave SORT for MERGE when the active range is already non-increasing, checked before each phase; a sorted range costs 0 phases.
- MERGE: node act-2 gets weight w[act-2]+w[act-1] and mask m[act-2]|m[act-1]. Node act-1 is cleared. Every symbol whose bit is set in either mask has code_len incremented. act decrements. If act==1, go to DONE; otherwise go to SORT.
- DONE: done=1 for one cycle, then IDLE.
- Degenerate case (only reachable with the configuration macro): act<=1 after LOAD means the single participating symbol gets code_len=1 and the FSM goes straight to DONE. If act==0, all lengths are 0.
- Reset: busy=0, done=0, code_len=0, state IDLE, all node weights and masks 0. Reset mid-build aborts with no done pulse.

## Timing
- start at cycle T → LOAD at T+1, busy=1 from T+1.
- Each merge round is at most act sort cycles plus 1 merge cycle.
- Worst-case latency from start to done is ≤ 2 + Σ_{a=2..N_SYM}(a+1) cycles.
- code_len changes only in LOAD (cleared) and MERGE. It is stable and valid from the done cycle onward.
- start in the same cycle as done is ignored, because the FSM is not yet in IDLE.

## Configuration
- HUFF_SKIP_ZERO_EN defined: symbols with count 0 are excluded in LOAD, keep code_len=0, and never appear in any mask.
- HUFF_SKIP_ZERO_EN undefined: all N_SYM symbols participate and act starts at N_SYM. Zero counts are treated as weight 0.

## Structure
- huffman_pkg holds:
  - the state enum
  - the LEN_W/W_W computation functions
  - the node struct {weight, mask}
- Sub-module huffman_cmp_swap is one compare-exchange cell (strict-greater swap of two node structs plus an enable). The top instantiates N_SYM-1 cells and selects even or odd phase and active range.

## Test plan
- counts {32,16,8,4,2,2} → code_len {1,2,3,4,5,5}, exactly one done pulse, busy low afterwards.
- counts all 1 → multiset of code_len is {2,2,3,3,3,3}, Σlen=16, Kraft sum equals 1.
- counts already sorted descending {9,7,5,3,2,1} → SORT exits with 0 phases on the first round. Cycle count matches the model, code_len matches the reference Huffman lengths, and the Kraft sum equals 1.
- start pulsed again mid-build → ignored; first result unchanged. Assert reset low mid-SORT → outputs 0, no done; a later start completes normally.
- HUFF_SKIP_ZERO_EN with {5,0,0,0,0,3} → code_len {1,0,0,0,0,1}. With {0,0,7,0,0,0} → {0,0,1,0,0,0}.
- N_SYM=8, CNT_W=12, all counts 4095 → no weight overflow, all lengths 3.
